pc_fetch: RTL and testbench
===========================

# pc_fetch

Parametrised program-counter and instruction-fetch unit. It generates sequential fetch addresses, reads instructions from the shared instruction SRAM (RAM2) whenever the memory arbiter grants it, and buffers them with their addresses in a DEPTH-entry prefetch queue. The queue feeds decode through a valid/ready handshake. Branch and interrupt redirects flush the queue and restart fetch. The unit sits between the RAM2 arbiter and the IF/ID pipeline register.

## Interface
- AW, 16, address width (PC, RAM2 address, target/EPC inputs)
- DW, 16, instruction width
- DEPTH, 2, prefetch-queue entries; power of two, ≥2
- RESET_VEC, 0, fetch address after reset (AW bits)
- pfi_clk  in  1  clock, all state on rising edge
- pfi_rst  in  1  asynchronous, active-low reset
- pfi_en  in  1  global enable; low freezes all state (no fetch, pop or redirect)
- pfi_branch  in  1  branch redirect request
- pfi_new_addr  in  AW  branch target
- pfi_interrupt  in  1  interrupt/exception redirect request
- pfi_epc  in  AW  interrupt target
- pfi_ram_grant  in  1  RAM2 available to fetch this cycle
- pfi_ram_data  in  DW  RAM2 read data, valid in the cycle oe_n is low
- pfi_ready  in  1  decode accepts head instruction
- pfo_ram_addr  out  AW  fetch address (= fetch PC)
- pfo_ram_oe_n  out  1  RAM2 output enable, active-low
- pfo_valid  out  1  queue non-empty
- pfo_instr  out  DW  head instruction
- pfo_pc  out  AW  address of head instruction
- pfo_count  out  clog2(DEPTH+1)  queue occupancy

## Operation
- State: fetch PC (fpc), a queue of {pc, instr} pairs, read/write pointers, and count.
- Redirect: when pfi_en=1 and pfi_interrupt=1, fpc←pfi_epc. Otherwise, when pfi_en=1 and pfi_branch=1, fpc←pfi_new_addr. Interrupt beats branch when both are asserted.
- On redirect the queue flushes (count←0, pointers←0). No fetch is issued that cycle (oe_n=1), and any pop that cycle is discarded.
- Fetch condition: fetch = pfi_rst & pfi_en & pfi_ram_grant & (count<DEPTH) & no redirect.
- pfo_ram_oe_n = ~fetch, combinational. pfo_ram_addr = fpc at all times.
- On the fetching edge, {fpc, pfi_ram_data} is pushed to the queue and fpc←fpc+1 modulo 2^AW. AW'hFFFF..F wraps to 0.
- A full queue blocks fetch even if a pop occurs in the same cycle. There is no combinational path from pfi_ready to RAM2.
- Pop: when pfi_en & pfo_valid & pfi_ready, the head is removed. Simultaneous push and pop leaves count unchanged.
- Head outputs come straight from the queue storage. pfo_instr and pfo_pc are undefined-but-stable while pfo_valid=0 (they must not be X after reset; drive 0).
- pfi_ready while pfo_valid=0 has no effect.
- pfi_en=0: every register holds, oe_n=1, and redirects are ignored (not latched).

## Timing
- Reset, asynchronous and immediate: fpc=RESET_VEC, count=0, pfo_valid=0, pfo_instr=0, pfo_pc=0, pfo_ram_oe_n=1, pfo_ram_addr=RESET_VEC.
- Fetch latency: 1 cycle. An instruction read in cycle N is presented with pfo_valid=1 from cycle N+1.
- Sustained throughput: 1 instruction/cycle with grant and ready held high (DEPTH≥2).
- Redirect latency: a redirect sampled at edge N causes the target to be fetched in cycle N+1. The target is valid at decode in cycle N+2.
- Grant low in cycle N: no push at edge N. fpc holds and count decreases only by pops.

## Test plan
- Reset release with grant=1, ready=1: oe_n low from the first cycle; addresses 0,1,2,… are fetched; pfo_pc sequence 0,1,2 appears one cycle behind pfo_ram_addr; pfo_valid rises in cycle 2.
- Backpressure, DEPTH=2, ready=0: exactly two fetches, then count=2 and oe_n=1. Raising ready pops one per cycle; fetch resumes the cycle after count drops below 2; instruction order is preserved.
- Branch to 0x0100 with count=2: the queue empties and pfo_valid=0 the next cycle; pfo_ram_addr=0x0100; the next head is pfo_pc=0x0100; the old entries are never presented.
- Branch (0x0100) and interrupt (epc=0x0008) asserted together: fetch resumes at 0x0008.
- fpc=0xFFFF, fetch: the next pfo_ram_addr is 0x0000; the pushed entry has pfo_pc=0xFFFF.
- Reset asserted mid-stream with count=1 and en=0/grant toggling: outputs go to their reset values immediately, without a clock edge; after release, fetch restarts at RESET_VEC.

Source files
------------

// File: rtl/pc_fetch.sv
// Program counter and instruction fetch unit: fetches sequentially from RAM2 when granted
// and buffers {pc, instr} pairs in a small prefetch queue feeding decode.
module pc_fetch #(
  parameter int unsigned   AW        = 16,
  parameter int unsigned   DW        = 16,
  parameter int unsigned   DEPTH     = 2,
  parameter logic [AW-1:0] RESET_VEC = '0
) (
  input  logic                       pfi_clk,
  input  logic                       pfi_rst,
  input  logic                       pfi_en,
  input  logic                       pfi_branch,
  input  logic [AW-1:0]              pfi_new_addr,
  input  logic                       pfi_interrupt,
  input  logic [AW-1:0]              pfi_epc,
  input  logic                       pfi_ram_grant,
  input  logic [DW-1:0]              pfi_ram_data,
  input  logic                       pfi_ready,
  output logic [AW-1:0]              pfo_ram_addr,
  output logic                       pfo_ram_oe_n,
  output logic                       pfo_valid,
  output logic [DW-1:0]              pfo_instr,
  output logic [AW-1:0]              pfo_pc,
  output logic [$clog2(DEPTH+1)-1:0] pfo_count
);

  localparam int unsigned   CW   = $clog2(DEPTH + 1);
  localparam int unsigned   PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [AW-1:0] r_fpc;
  logic [AW-1:0] r_q_pc    [DEPTH];
  logic [DW-1:0] r_q_instr [DEPTH];
  logic [PW-1:0] r_wptr;
  logic [PW-1:0] r_rptr;
  logic [CW-1:0] r_count;

  logic          w_redirect;
  logic [AW-1:0] w_target;
  logic          w_valid;
  logic          w_fetch;
  logic          w_pop;
  logic [AW-1:0] w_fpc_nxt;
  logic [PW-1:0] w_wptr_nxt;
  logic [PW-1:0] w_rptr_nxt;
  logic [CW-1:0] w_count_nxt;

  // Interrupt takes priority over branch; both are ignored while disabled.
  always_comb begin
    w_redirect = pfi_en & (pfi_interrupt | pfi_branch);
    w_target   = pfi_interrupt ? pfi_epc : pfi_new_addr;
    w_valid    = (r_count != '0);
    // Full check uses the registered count only, keeping pfi_ready off the RAM2 path.
    w_fetch    = pfi_rst & pfi_en & pfi_ram_grant & (r_count < FULL) & ~w_redirect;
    w_pop      = pfi_en & w_valid & pfi_ready & ~w_redirect;
  end

  always_comb begin
    w_fpc_nxt   = r_fpc;
    w_wptr_nxt  = r_wptr;
    w_rptr_nxt  = r_rptr;
    w_count_nxt = r_count;
    if (w_redirect) begin
      w_fpc_nxt   = w_target;
      w_wptr_nxt  = '0;
      w_rptr_nxt  = '0;
      w_count_nxt = '0;
    end else begin
      if (w_fetch) begin
        w_fpc_nxt  = r_fpc + AW'(1);
        w_wptr_nxt = r_wptr + PW'(1);
      end
      if (w_pop) begin
        w_rptr_nxt = r_rptr + PW'(1);
      end
      unique case ({w_fetch, w_pop})
        2'b10:   w_count_nxt = r_count + CW'(1);
        2'b01:   w_count_nxt = r_count - CW'(1);
        default: w_count_nxt = r_count;
      endcase
    end
  end

  always_ff @(posedge pfi_clk or negedge pfi_rst) begin
    if (!pfi_rst) begin
      r_fpc   <= RESET_VEC;
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      r_fpc   <= w_fpc_nxt;
      r_wptr  <= w_wptr_nxt;
      r_rptr  <= w_rptr_nxt;
      r_count <= w_count_nxt;
    end
  end

  // Storage is cleared on reset so the head outputs read 0 rather than X.
  always_ff @(posedge pfi_clk or negedge pfi_rst) begin
    if (!pfi_rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_q_pc[i]    <= '0;
        r_q_instr[i] <= '0;
      end
    end else if (w_fetch) begin
      r_q_pc[r_wptr]    <= r_fpc;
      r_q_instr[r_wptr] <= pfi_ram_data;
    end
  end

  always_comb begin
    pfo_ram_addr = r_fpc;
    pfo_ram_oe_n = ~w_fetch;
    pfo_valid    = w_valid;
    pfo_instr    = r_q_instr[r_rptr];
    pfo_pc       = r_q_pc[r_rptr];
    pfo_count    = r_count;
  end

endmodule

// File: tb/tb_pc_fetch.sv
// Directed bench for pc_fetch (DEPTH=2); RAM2 is modelled as data = addr ^ 16'hA5A5.
module tb_pc_fetch;

  localparam int unsigned AW    = 16;
  localparam int unsigned DW    = 16;
  localparam int unsigned DEPTH = 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          en;
  logic          branch;
  logic [AW-1:0] new_addr;
  logic          interrupt;
  logic [AW-1:0] epc;
  logic          grant;
  logic [DW-1:0] ram_data;
  logic          ready;
  logic [AW-1:0] ram_addr;
  logic          oe_n;
  logic          valid;
  logic [DW-1:0] instr;
  logic [AW-1:0] pc;
  logic [1:0]    count;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  assign ram_data = ram_addr ^ 16'hA5A5;

  pc_fetch #(
    .AW       (AW),
    .DW       (DW),
    .DEPTH    (DEPTH),
    .RESET_VEC(16'h0000)
  ) u_dut (
    .pfi_clk      (clk),
    .pfi_rst      (rst_n),
    .pfi_en       (en),
    .pfi_branch   (branch),
    .pfi_new_addr (new_addr),
    .pfi_interrupt(interrupt),
    .pfi_epc      (epc),
    .pfi_ram_grant(grant),
    .pfi_ram_data (ram_data),
    .pfi_ready    (ready),
    .pfo_ram_addr (ram_addr),
    .pfo_ram_oe_n (oe_n),
    .pfo_valid    (valid),
    .pfo_instr    (instr),
    .pfo_pc       (pc),
    .pfo_count    (count)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [DW-1:0] mem(input logic [AW-1:0] a);
    return a ^ 16'hA5A5;
  endfunction

  task automatic check_head(input string tag, input logic [AW-1:0] exp_pc,
                            input logic [1:0] exp_cnt, input logic [AW-1:0] exp_addr);
    check_eq({tag, " valid"}, 32'(valid), 32'd1);
    check_eq({tag, " pc"}, 32'(pc), 32'(exp_pc));
    check_eq({tag, " instr"}, 32'(instr), 32'(mem(exp_pc)));
    check_eq({tag, " count"}, 32'(count), 32'(exp_cnt));
    check_eq({tag, " addr"}, 32'(ram_addr), 32'(exp_addr));
  endtask

  task automatic check_reset(input string tag);
    check_eq({tag, " addr"}, 32'(ram_addr), 32'h0);
    check_eq({tag, " oe_n"}, 32'(oe_n), 32'd1);
    check_eq({tag, " valid"}, 32'(valid), 32'd0);
    check_eq({tag, " instr"}, 32'(instr), 32'h0);
    check_eq({tag, " pc"}, 32'(pc), 32'h0);
    check_eq({tag, " count"}, 32'(count), 32'd0);
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b1; grant = 1'b1; ready = 1'b1;
    branch = 1'b0; interrupt = 1'b0; new_addr = '0; epc = '0;
    #1;
    check_reset("reset");
    #1 rst_n = 1'b1;
    #1;
    check_eq("first oe_n", 32'(oe_n), 32'd0);
    check_eq("first addr", 32'(ram_addr), 32'h0);

    // Streaming: head trails fetch address by one.
    tick(); check_head("s0", 16'h0000, 2'd1, 16'h0001);
    tick(); check_head("s1", 16'h0001, 2'd1, 16'h0002);
    tick(); check_head("s2", 16'h0002, 2'd1, 16'h0003);

    // Backpressure fills the queue then blocks fetch.
    ready = 1'b0;
    tick(); check_head("bp fill", 16'h0002, 2'd2, 16'h0004);
    check_eq("bp full oe_n", 32'(oe_n), 32'd1);
    tick(); check_head("bp hold", 16'h0002, 2'd2, 16'h0004);
    ready = 1'b1;
    #1 check_eq("full+pop oe_n", 32'(oe_n), 32'd1);
    tick(); check_head("bp pop", 16'h0003, 2'd1, 16'h0004);
    check_eq("bp resume oe_n", 32'(oe_n), 32'd0);
    tick(); check_head("bp resume", 16'h0004, 2'd1, 16'h0005);

    // Branch with a full queue.
    ready = 1'b0;
    tick(); check_head("pre-br", 16'h0004, 2'd2, 16'h0006);
    branch = 1'b1; new_addr = 16'h0100;
    #1 check_eq("br oe_n", 32'(oe_n), 32'd1);
    tick();
    check_eq("br valid", 32'(valid), 32'd0);
    check_eq("br count", 32'(count), 32'd0);
    check_eq("br addr", 32'(ram_addr), 32'h0100);
    branch = 1'b0; ready = 1'b1;
    #1 check_eq("post-br oe_n", 32'(oe_n), 32'd0);
    tick(); check_head("br tgt", 16'h0100, 2'd1, 16'h0101);

    // Interrupt beats branch.
    branch = 1'b1; interrupt = 1'b1; new_addr = 16'h0100; epc = 16'h0008;
    tick();
    check_eq("irq valid", 32'(valid), 32'd0);
    check_eq("irq addr", 32'(ram_addr), 32'h0008);
    branch = 1'b0; interrupt = 1'b0;
    tick(); check_head("irq tgt", 16'h0008, 2'd1, 16'h0009);

    // Address wrap.
    branch = 1'b1; new_addr = 16'hFFFF;
    tick(); check_eq("wrap addr", 32'(ram_addr), 32'hFFFF);
    branch = 1'b0;
    #1 check_eq("wrap oe_n", 32'(oe_n), 32'd0);
    tick(); check_head("wrap", 16'hFFFF, 2'd1, 16'h0000);

    // Disabled: redirects ignored, state frozen.
    en = 1'b0; branch = 1'b1; new_addr = 16'h1234;
    #1 check_eq("dis oe_n", 32'(oe_n), 32'd1);
    tick(); check_head("dis hold", 16'hFFFF, 2'd1, 16'h0000);
    branch = 1'b0;
    check_eq("dis no latch addr", 32'(ram_addr), 32'h0000);

    // Asynchronous reset mid-cycle.
    grant = 1'b0;
    #1 grant = 1'b1;
    #1 rst_n = 1'b0;
    #1 check_reset("async rst");
    en = 1'b1; grant = 1'b1; ready = 1'b1;
    #2 rst_n = 1'b1;
    #1;
    check_eq("restart oe_n", 32'(oe_n), 32'd0);
    check_eq("restart addr", 32'(ram_addr), 32'h0000);
    tick(); check_head("restart", 16'h0000, 2'd1, 16'h0001);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
